// File: rtl/switch_led_sequencer.sv
// Avalon-MM master that polls the switch PIO, debounces the reading and mirrors
// each newly accepted value into the LED PIO without CPU involvement.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for a prescaler tick with polling enabled
// RD_ADDR | switch PIO read cycle (chipselect asserted)
// RD_CAPT | switch readdata valid, sample captured
// EVAL    | debounce update, decide whether a new value is accepted
// WR_LED  | single-cycle write of the accepted value to the LED PIO
module switch_led_sequencer #(
  parameter int POLL_DIV       = 50000,
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        irq_ack,
  output logic [1:0]  sw_address,
  output logic        sw_chipselect,
  input  logic [31:0] sw_readdata,
  output logic [1:0]  led_address,
  output logic        led_chipselect,
  output logic        led_write_n,
  output logic [31:0] led_writedata,
  output logic [7:0]  stable_value,
  output logic        change_pulse,
  output logic        irq
);

  localparam int              PW         = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(POLL_DIV - 1);
  localparam logic [3:0]      DB_TARGET  = 4'(DEBOUNCE_COUNT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_CAPT = 3'd2,
    EVAL    = 3'd3,
    WR_LED  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] presc;
  logic          tick;
  logic [7:0]    sample;
  logic [7:0]    candidate;
  logic [7:0]    cand_next;
  logic [7:0]    stable_next;
  logic [3:0]    count;
  logic [3:0]    count_next;
  logic          accept;
  logic          unused_readdata;

  assign unused_readdata = ^sw_readdata[31:8];

  assign sw_address    = 2'b00;
  assign led_address   = 2'b00;
  assign led_writedata = {24'b0, stable_value};

  // Ticks run free of the FSM; one landing outside IDLE is simply lost.
  assign tick = enable && (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (!enable || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    state_next  = state;
    cand_next   = candidate;
    count_next  = count;
    stable_next = stable_value;
    accept      = 1'b0;
    case (state)
      IDLE:    if (tick) state_next = RD_ADDR;
      RD_ADDR: state_next = RD_CAPT;
      RD_CAPT: state_next = EVAL;
      EVAL: begin
        if (sample == candidate) begin
          count_next = (count >= DB_TARGET) ? DB_TARGET : count + 4'd1;
        end else begin
          cand_next  = sample;
          count_next = 4'd1;
        end
        if ((count_next == DB_TARGET) && (cand_next != stable_value)) begin
          accept      = 1'b1;
          stable_next = cand_next;
          state_next  = WR_LED;
        end else begin
          state_next = IDLE;
        end
      end
      WR_LED:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      sample         <= 8'h00;
      candidate      <= 8'h00;
      count          <= 4'd0;
      stable_value   <= 8'h00;
      change_pulse   <= 1'b0;
      irq            <= 1'b0;
      sw_chipselect  <= 1'b0;
      led_chipselect <= 1'b0;
      led_write_n    <= 1'b1;
    end else begin
      state          <= state_next;
      candidate      <= cand_next;
      count          <= count_next;
      stable_value   <= stable_next;
      change_pulse   <= accept;
      sw_chipselect  <= (state_next == RD_ADDR);
      led_chipselect <= (state_next == WR_LED);
      led_write_n    <= (state_next != WR_LED);
      if (state == RD_CAPT) sample <= sw_readdata[7:0];
      // Holding the set through the visible pulse cycle lets a coincident ack lose.
      irq <= accept | change_pulse | (irq & ~irq_ack);
    end
  end

endmodule
